// File: rtl/alarm_controller.sv
// alarm_controller
//
// Sequential door-alarm controller. It adds an exit delay after arming, an
// entry delay after the door opens, a siren that sounds for a fixed time,
// and a memory state that records that the alarm went off. All delays are
// counted in clk_2 cycles. Every output comes straight from a flop.
//
// Ports
//   clk_2        in   1      system clock, rising edge
//   reset_n      in   1      synchronous active-low reset
//   porta        in   1      1 = door open
//   relogio      in   1      1 = arming window active
//   interruptor  in   1      1 = owner override key
//   alarme       out  1      siren, high only while triggered
//   armado       out  1      high in ARMADO, ENTRADA, DISPARADO, MEMORIA
//   estado       out  3      current state code
//   contagem     out  CNT_W  remaining cycles of a timed state, else 0
module alarm_controller #(
  parameter int unsigned EXIT_DELAY  = 8,
  parameter int unsigned ENTRY_DELAY = 4,
  parameter int unsigned SIREN_TIME  = 16,
  parameter int unsigned CNT_W       = 5
) (
  input  logic             clk_2,
  input  logic             reset_n,
  input  logic             porta,
  input  logic             relogio,
  input  logic             interruptor,
  output logic             alarme,
  output logic             armado,
  output logic [2:0]       estado,
  output logic [CNT_W-1:0] contagem
);

  typedef enum logic [2:0] {
    DESARMADO = 3'd0,
    SAIDA     = 3'd1,
    ARMADO    = 3'd2,
    ENTRADA   = 3'd3,
    DISPARADO = 3'd4,
    MEMORIA   = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] CNT_EXIT  = CNT_W'(EXIT_DELAY);
  localparam logic [CNT_W-1:0] CNT_ENTRY = CNT_W'(ENTRY_DELAY);
  localparam logic [CNT_W-1:0] CNT_SIREN = CNT_W'(SIREN_TIME);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] next_cnt;
  logic             desarme;

  // Disarm is possible from any state: the arming window closing, or the
  // owner key turned while the door is shut. The key does nothing with the
  // door open, so an intruder holding the door cannot use it.
  assign desarme = ~relogio | (interruptor & ~porta);

  // Next-state and next-count logic. The timed states count down to 1 and
  // act on that last cycle, so contagem never drops below 1 while timing.
  always_comb begin
    next_state = state;
    next_cnt   = contagem;
    if (desarme) begin
      next_state = DESARMADO;
      next_cnt   = '0;
    end else begin
      case (state)
        DESARMADO: begin
          next_state = SAIDA;
          next_cnt   = CNT_EXIT;
        end
        SAIDA: begin
          if (contagem > CNT_ONE) begin
            next_cnt = contagem - CNT_ONE;
          end else if (porta) begin
            // Door still open at the end of the exit delay: start over.
            next_cnt = CNT_EXIT;
          end else begin
            next_state = ARMADO;
            next_cnt   = '0;
          end
        end
        ARMADO: begin
          next_cnt = '0;
          if (porta) begin
            next_state = ENTRADA;
            next_cnt   = CNT_ENTRY;
          end
        end
        ENTRADA: begin
          // Closing the door again does not cancel the entry countdown.
          if (contagem > CNT_ONE) begin
            next_cnt = contagem - CNT_ONE;
          end else begin
            next_state = DISPARADO;
            next_cnt   = CNT_SIREN;
          end
        end
        DISPARADO: begin
          if (contagem > CNT_ONE) begin
            next_cnt = contagem - CNT_ONE;
          end else begin
            next_state = MEMORIA;
            next_cnt   = '0;
          end
        end
        MEMORIA: begin
          next_cnt = '0;
          if (porta) begin
            next_state = DISPARADO;
            next_cnt   = CNT_SIREN;
          end
        end
        default: begin
          next_state = DESARMADO;
          next_cnt   = '0;
        end
      endcase
    end
  end

  // State register. alarme and armado are decoded from the next state so
  // that they are registered and line up with estado on the same cycle.
  always_ff @(posedge clk_2) begin
    if (!reset_n) begin
      state    <= DESARMADO;
      contagem <= '0;
      alarme   <= 1'b0;
      armado   <= 1'b0;
    end else begin
      state    <= next_state;
      contagem <= next_cnt;
      alarme   <= (next_state == DISPARADO);
      armado   <= (next_state == ARMADO) || (next_state == ENTRADA) ||
                  (next_state == DISPARADO) || (next_state == MEMORIA);
    end
  end

  assign estado = state;

endmodule
